// File: rtl/jstk2_spi_sequencer.sv
// JSTK2 SPI master sequencer: frames one 5-byte transaction and unpacks X/Y/buttons.
// Optional feature: define JSTK2_AUTO_POLL_EN to self-start a poll (cmd 8'hC0) every POLL_CYC idle cycles.
module jstk2_spi_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLK_DIV      = 50,
  parameter int SS_SETUP_CYC = 1500,
  parameter int BYTE_GAP_CYC = 1000,
  parameter int POLL_CYC     = 10000000
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] i_cmd,
  input  logic [DATA_WIDTH-1:0] i_param_1,
  input  logic [DATA_WIDTH-1:0] i_param_2,
  input  logic [DATA_WIDTH-1:0] i_param_3,
  input  logic [DATA_WIDTH-1:0] i_param_4,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_data_valid,
  output logic                  o_ss_n,
  output logic                  o_sclk,
  output logic                  o_sclk_z,
  output logic                  o_fetch,
  output logic                  o_cmd_valid,
  output logic [DATA_WIDTH-1:0] o_cmd,
  output logic [DATA_WIDTH-1:0] o_param_1,
  output logic [DATA_WIDTH-1:0] o_param_2,
  output logic [DATA_WIDTH-1:0] o_param_3,
  output logic [DATA_WIDTH-1:0] o_param_4,
  output logic [9:0]            o_x,
  output logic [9:0]            o_y,
  output logic [1:0]            o_buttons,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rx_err
);
  localparam int CNT_MAX0 = (CLK_DIV > SS_SETUP_CYC) ? CLK_DIV : SS_SETUP_CYC;
  localparam int CNT_MAX  = (CNT_MAX0 > BYTE_GAP_CYC) ? CNT_MAX0 : BYTE_GAP_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_GAP     = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [3:0]            tog_r, tog_s;
  logic [2:0]            idx_r, idx_s;
  logic                  seen_r, seen_s;
  logic                  sclk_s, active_s;
  logic                  user_go_s, auto_go_s, accept_s;
  logic                  store_s, err_set_s, finish_s;
  logic [DATA_WIDTH-1:0] rx_buf_r [5];

`ifdef JSTK2_AUTO_POLL_EN
  localparam int POLL_W = $clog2(POLL_CYC + 1);
  logic [POLL_W-1:0] poll_r;

  // Idle-time poll counter; cleared whenever the sequencer leaves IDLE.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      poll_r <= '0;
    end else if (state_r == ST_IDLE && !accept_s) begin
      poll_r <= poll_r + POLL_W'(1);
    end else begin
      poll_r <= '0;
    end
  end

  assign auto_go_s = (poll_r == POLL_W'(POLL_CYC - 1)) && !i_start && !i_abort;
`else
  assign auto_go_s = 1'b0;
`endif

  assign user_go_s = i_start && !i_abort;

  // Next-state, counters and event strobes; abort overrides everything outside IDLE.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    tog_s     = tog_r;
    idx_s     = idx_r;
    seen_s    = seen_r;
    sclk_s    = o_sclk;
    accept_s  = 1'b0;
    store_s   = 1'b0;
    err_set_s = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s  = '0;
        tog_s  = 4'd0;
        sclk_s = 1'b0;
        if (user_go_s || auto_go_s) begin
          accept_s = 1'b1;
          idx_s    = 3'd0;
          state_s  = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          cnt_s   = '0;
          state_s = ST_SHIFT;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        seen_s = 1'b0;
        if (cnt_r == DIV_LAST) begin
          cnt_s  = '0;
          sclk_s = ~o_sclk;
          tog_s  = tog_r + 4'd1;
          if (tog_r == 4'd15) begin
            state_s = ST_GAP;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (i_rx_data_valid && !seen_r) begin
          store_s = 1'b1;
          seen_s  = 1'b1;
        end else begin
          seen_s = seen_r;
        end
        if (cnt_r == GAP_LAST) begin
          cnt_s     = '0;
          err_set_s = !seen_r && !i_rx_data_valid;
          if (idx_r == 3'd4) begin
            state_s = ST_RELEASE;
          end else begin
            idx_s   = idx_r + 3'd1;
            state_s = ST_SHIFT;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s    = '0;
          finish_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
    if (state_r != ST_IDLE && i_abort) begin
      state_s   = ST_IDLE;
      cnt_s     = '0;
      tog_s     = 4'd0;
      sclk_s    = 1'b0;
      store_s   = 1'b0;
      err_set_s = 1'b0;
      finish_s  = 1'b0;
    end else begin
      active_s = 1'b0;
    end
    active_s = (state_s == ST_SETUP) || (state_s == ST_SHIFT) || (state_s == ST_GAP);
  end

  // State, receive buffer and all registered outputs.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      tog_r       <= 4'd0;
      idx_r       <= 3'd0;
      seen_r      <= 1'b0;
      o_ss_n      <= 1'b1;
      o_fetch     <= 1'b1;
      o_cmd_valid <= 1'b0;
      o_sclk      <= 1'b0;
      o_sclk_z    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rx_err    <= 1'b0;
      o_cmd       <= '0;
      o_param_1   <= '0;
      o_param_2   <= '0;
      o_param_3   <= '0;
      o_param_4   <= '0;
      o_x         <= 10'd0;
      o_y         <= 10'd0;
      o_buttons   <= 2'd0;
      for (int i = 0; i < 5; i++) rx_buf_r[i] <= '0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      tog_r       <= tog_s;
      idx_r       <= idx_s;
      seen_r      <= seen_s;
      o_ss_n      <= ~active_s;
      o_fetch     <= ~active_s;
      o_cmd_valid <= active_s;
      o_sclk      <= sclk_s;
      o_sclk_z    <= o_sclk;
      o_busy      <= (state_s != ST_IDLE);
      o_done      <= finish_s;
      if (accept_s) begin
        o_rx_err <= 1'b0;
        if (user_go_s) begin
          o_cmd     <= i_cmd;
          o_param_1 <= i_param_1;
          o_param_2 <= i_param_2;
          o_param_3 <= i_param_3;
          o_param_4 <= i_param_4;
        end else begin
          o_cmd     <= DATA_WIDTH'(8'hC0);
          o_param_1 <= '0;
          o_param_2 <= '0;
          o_param_3 <= '0;
          o_param_4 <= '0;
        end
      end else if (err_set_s) begin
        o_rx_err <= 1'b1;
      end
      if (store_s) rx_buf_r[idx_r] <= i_rx_data;
      if (finish_s) begin
        o_x       <= {rx_buf_r[1][1:0], rx_buf_r[0][7:0]};
        o_y       <= {rx_buf_r[3][1:0], rx_buf_r[2][7:0]};
        o_buttons <= rx_buf_r[4][1:0];
      end
    end
  end
endmodule

// File: tb/tb_jstk2_spi_sequencer.sv
// Directed bench for jstk2_spi_sequencer with a small SPI slave responder model.
module tb_jstk2_spi_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] cmd, p1, p2, p3, p4;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ss_n, sclk, sclk_z, fetch, cmd_valid, busy, done, rx_err;
  logic [7:0] o_cmd, o_p1, o_p2, o_p3, o_p4;
  logic [9:0] x, y;
  logic [1:0] buttons;

  int checks = 0;
  int errors = 0;
  logic [7:0] slave_bytes [5];
  int  withhold_idx = -1;
  int  txn_rise = 0, total_rise = 0, done_cnt = 0;
  logic prev_sclk = 1'b0;

  jstk2_spi_sequencer #(.DATA_WIDTH(8), .CLK_DIV(2), .SS_SETUP_CYC(4), .BYTE_GAP_CYC(6), .POLL_CYC(100)) dut (
    .i_clk(clk), .i_n_reset(rst_n), .i_start(start), .i_abort(abort),
    .i_cmd(cmd), .i_param_1(p1), .i_param_2(p2), .i_param_3(p3), .i_param_4(p4),
    .i_rx_data(rx_data), .i_rx_data_valid(rx_valid),
    .o_ss_n(ss_n), .o_sclk(sclk), .o_sclk_z(sclk_z), .o_fetch(fetch), .o_cmd_valid(cmd_valid),
    .o_cmd(o_cmd), .o_param_1(o_p1), .o_param_2(o_p2), .o_param_3(o_p3), .o_param_4(o_p4),
    .o_x(x), .o_y(y), .o_buttons(buttons), .o_busy(busy), .o_done(done), .o_rx_err(rx_err)
  );

  always #5 clk = ~clk;

  // Slave model: answers one byte per completed 8-clock group, and counts edges/done pulses.
  always @(negedge clk) begin
    rx_valid = 1'b0;
    if (ss_n) begin
      txn_rise = 0;
    end else if (!prev_sclk && sclk) begin
      txn_rise++;
      total_rise++;
    end else if (prev_sclk && !sclk && txn_rise > 0 && (txn_rise % 8) == 0) begin
      if ((txn_rise / 8 - 1) != withhold_idx) begin
        rx_valid = 1'b1;
        rx_data  = slave_bytes[txn_rise / 8 - 1];
      end
    end
    if (done) done_cnt++;
    prev_sclk = sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slave(input logic [7:0] b0, b1, b2, b3, b4, input int wh);
    slave_bytes[0] = b0; slave_bytes[1] = b1; slave_bytes[2] = b2;
    slave_bytes[3] = b3; slave_bytes[4] = b4;
    withhold_idx = wh;
  endtask

  task automatic run_start(input logic [7:0] c);
    cmd = c; p1 = 8'h01; p2 = 8'h02; p3 = 8'h03; p4 = 8'h04;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int lat, r0, d0, n;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cmd = 8'h00; p1 = 8'h00; p2 = 8'h00; p3 = 8'h00; p4 = 8'h00;
    set_slave(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1);
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 32'(ss_n), 32'd1);
    chk("rst_fetch", 32'(fetch), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_busy_cv", 32'({busy, cmd_valid, done, rx_err}), 32'd0);
    chk("rst_xy", 32'({x, y, buttons}), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_ss_busy", 32'({ss_n, fetch, busy, sclk}), 32'b1100);
    chk("idle_no_done", 32'(done_cnt), 32'd0);

    // Transaction 1: nominal read.
    set_slave(8'h34, 8'h02, 8'hF0, 8'h01, 8'h03, -1);
    r0 = total_rise; d0 = done_cnt;
    run_start(8'h84);
    chk("t1_active", 32'({busy, ss_n, fetch, cmd_valid}), 32'b1001);
    chk("t1_latch", 32'({o_cmd, o_p1, o_p4}), 32'h840104);
    wait_done(lat);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_latency", 32'(lat), 32'd200);
    chk("t1_rises", 32'(total_rise - r0), 32'd40);
    chk("t1_x", 32'(x), 32'h234);
    chk("t1_y", 32'(y), 32'h1F0);
    chk("t1_btn", 32'(buttons), 32'b11);
    chk("t1_end_bus", 32'({ss_n, fetch, busy, rx_err}), 32'b1100);
    @(negedge clk);
    chk("t1_done_pulse", 32'({done, 8'(done_cnt - d0)}), 32'h001);

    // Transaction 2: byte 2 withheld, start+new cmd pulsed mid-shift.
    set_slave(8'h11, 8'h01, 8'hAA, 8'h02, 8'h00, 2);
    d0 = done_cnt;
    run_start(8'h84);
    n = 0;
    while (!sclk && n < 100) begin @(negedge clk); n++; end
    chk("t2_in_shift", 32'(sclk), 32'd1);
    cmd = 8'hC0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2_cmd_kept", 32'(o_cmd), 32'h84);
    wait_done(lat);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_rx_err", 32'(rx_err), 32'd1);
    chk("t2_x", 32'(x), 32'h111);
    chk("t2_y_kept", 32'(y), 32'h2F0);
    chk("t2_btn", 32'(buttons), 32'b00);
    repeat (20) @(negedge clk);
    chk("t2_not_queued", 32'({busy, 8'(done_cnt - d0)}), 32'h001);

    // Transaction 3: aborted during third SHIFT.
    set_slave(8'h55, 8'h03, 8'h66, 8'h01, 8'h02, -1);
    r0 = total_rise; d0 = done_cnt;
    run_start(8'h84);
    chk("t3_err_clr", 32'(rx_err), 32'd0);
    n = 0;
    while ((total_rise - r0) < 17 && n < 300) begin @(negedge clk); n++; end
    chk("t3_reach", 32'(total_rise - r0), 32'd17);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_abort", 32'({ss_n, sclk, busy, fetch, cmd_valid}), 32'b10010);
    repeat (20) @(negedge clk);
    chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t3_x_kept", 32'({x, y}), 32'({10'h111, 10'h2F0}));

    // Transaction 4: normal run after abort.
    set_slave(8'h9A, 8'h01, 8'h3C, 8'h02, 8'h01, -1);
    r0 = total_rise;
    run_start(8'h84);
    wait_done(lat);
    chk("t4_latency", 32'(lat), 32'd200);
    chk("t4_rises", 32'(total_rise - r0), 32'd40);
    chk("t4_xyb", 32'({x, y, buttons}), 32'({10'h19A, 10'h23C, 2'b01}));
    chk("t4_rx_err", 32'(rx_err), 32'd0);

    // Async reset mid-transaction.
    run_start(8'h5A);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", 32'({ss_n, fetch, sclk, busy, cmd_valid}), 32'b11000);
    chk("arst_regs", 32'({x, o_cmd}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
